fetch_unit_btb: RTL and testbench

- Parametrised next-generation PC generator for the mips_core fetch stage.
- Holds the registered current PC and a combinational next PC that feeds the synchronous i_cache.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so predicted-taken branches redirect fetch without waiting for decode or execute.
- Sits between hazard control, the branch-resolution path in EX, and the i_cache address input.

---
 rtl/mips_core_pkg.sv | 26 ++
 rtl/btb_array.sv | 84 ++++++++
 rtl/fetch_unit_btb.sv | 71 +++++++
 tb/tb_fetch_unit_btb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared types and constants for the mips_core blocks.
// Provides the BTB 2-bit saturating counter type, its named states, the
// core-wide default address width and the counter next-state helper.
package mips_core_pkg;

  // Default byte-address width shared by the fetch, decode and cache blocks.
  localparam int CORE_ADDR_WIDTH = 26;

  typedef logic [1:0] btb_counter_t;

  localparam btb_counter_t CNT_STRONG_NT = 2'd0;
  localparam btb_counter_t CNT_WEAK_NT   = 2'd1;
  localparam btb_counter_t CNT_WEAK_T    = 2'd2;
  localparam btb_counter_t CNT_STRONG_T  = 2'd3;

  // Saturating step: taken moves towards CNT_STRONG_T, not-taken towards
  // CNT_STRONG_NT, and both ends hold.
  function automatic btb_counter_t cnt_next(input btb_counter_t cnt,
                                            input logic         taken);
    if (taken) begin
      return (cnt == CNT_STRONG_T) ? cnt : btb_counter_t'(cnt + 2'd1);
    end
    return (cnt == CNT_STRONG_NT) ? cnt : btb_counter_t'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer storage.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset (clears valid bits)
//   rd_pc             lookup address (combinational read port)
//   rd_taken          lookup hit with counter in a taken state
//   rd_target         stored target of the indexed entry
//   wr_valid          a resolved branch is reported this cycle
//   wr_pc             address of the resolved branch
//   wr_taken          actual outcome
//   wr_target         actual taken target
// pc[1:0] never participates in indexing or tag compare.
module btb_array
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH  = CORE_ADDR_WIDTH,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_pc,
  output logic                  rd_taken,
  output logic [ADDR_WIDTH-1:0] rd_target,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_pc,
  input  logic                  wr_taken,
  input  logic [ADDR_WIDTH-1:0] wr_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0]  target_mem [BTB_ENTRIES];
  btb_counter_t           cnt_mem    [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;

  // Byte-offset bits are deliberately ignored.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[ADDR_WIDTH-1:IDX_W+2];

  assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign wr_hit    = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
  // Read returns pre-update contents: a same-cycle write is not bypassed.
  assign rd_taken  = rd_hit && (cnt_mem[rd_idx] >= CNT_WEAK_T);
  assign rd_target = target_mem[rd_idx];

  // Valid bits are the only state that needs reset.
  // NOTE: non-blocking (<=) in clocked blocks so every register samples its
  // inputs from before the edge; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_valid && !wr_hit && wr_taken) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/target/counter arrays are not reset; the cleared valid bit
  // already masks them, and leaving them unreset lets them map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      if (wr_hit) begin
        cnt_mem[wr_idx] <= cnt_next(cnt_mem[wr_idx], wr_taken);
        if (wr_taken) begin
          target_mem[wr_idx] <= wr_target;
        end
      end else if (wr_taken) begin
        tag_mem[wr_idx]    <= wr_tag;
        target_mem[wr_idx] <= wr_target;
        cnt_mem[wr_idx]    <= CNT_WEAK_T;
      end
    end
  end

endmodule

// File: rtl/fetch_unit_btb.sv
// Fetch-stage next-PC generator with branch target buffer.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   i_stall            hold the PC (hazard control)
//   i_redirect_valid   correction from EX; beats stall
//   i_redirect_pc      corrected fetch address
//   i_update_*         resolved-branch report that trains the BTB
//   o_pc_current       registered PC being fetched this cycle
//   o_pc_next          combinational next PC driving the i_cache address
//   o_pred_taken       BTB prediction for o_pc_current
//   o_pred_target      predicted target (meaningful when o_pred_taken is 1)
module fetch_unit_btb
  import mips_core_pkg::*;
#(
  parameter int                   ADDR_WIDTH  = CORE_ADDR_WIDTH,
  parameter int                   BTB_ENTRIES = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  input  logic                  i_update_valid,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic                  i_update_taken,
  input  logic [ADDR_WIDTH-1:0] i_update_target,
  output logic [ADDR_WIDTH-1:0] o_pc_current,
  output logic [ADDR_WIDTH-1:0] o_pc_next,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_target
);

  btb_array #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (o_pc_current),
    .rd_taken  (o_pred_taken),
    .rd_target (o_pred_target),
    .wr_valid  (i_update_valid),
    .wr_pc     (i_update_pc),
    .wr_taken  (i_update_taken),
    .wr_target (i_update_target)
  );

  // Redirect outranks stall so a flush arriving during a hazard is not lost.
  // NOTE: o_pc_next gets a default before the priority chain so every path
  // assigns it and no latch is inferred.
  always_comb begin
    o_pc_next = o_pc_current + ADDR_WIDTH'(4);
    if (i_redirect_valid) begin
      o_pc_next = i_redirect_pc;
    end else if (i_stall) begin
      o_pc_next = o_pc_current;
    end else if (o_pred_taken) begin
      o_pc_next = o_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_pc_current <= RESET_PC;
    end else begin
      o_pc_current <= o_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit_btb.sv
// Self-checking bench for fetch_unit_btb (ADDR_WIDTH=26, BTB_ENTRIES=16).
// Each step drives inputs just after a rising edge, queues the expected
// current PC, next PC and prediction, then pops and compares at the falling edge.
module tb_fetch_unit_btb;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, redir_v, upd_v, upd_taken;
  logic [AW-1:0] redir_pc, upd_pc, upd_tgt;
  logic [AW-1:0] pc_cur, pc_nxt, pred_tgt;
  logic          pred_taken;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] cur;
    logic [AW-1:0] nxt;
    logic          pred;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  fetch_unit_btb #(
    .ADDR_WIDTH  (AW),
    .BTB_ENTRIES (16),
    .RESET_PC    ('0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall          (stall),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .i_update_valid   (upd_v),
    .i_update_pc      (upd_pc),
    .i_update_taken   (upd_taken),
    .i_update_target  (upd_tgt),
    .o_pc_current     (pc_cur),
    .o_pc_next        (pc_nxt),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_tgt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // One cycle: apply stimulus, queue expectations, compare mid-cycle, advance.
  task automatic step(input string tag,
                      input logic stl, input logic rv, input logic [AW-1:0] rpc,
                      input logic uv, input logic [AW-1:0] upc,
                      input logic ut, input logic [AW-1:0] utg,
                      input logic [AW-1:0] e_cur, input logic [AW-1:0] e_nxt,
                      input logic e_pred);
    exp_t e;
    string t;
    stall = stl; redir_v = rv; redir_pc = rpc;
    upd_v = uv;  upd_pc  = upc; upd_taken = ut; upd_tgt = utg;
    exp_q.push_back('{cur: e_cur, nxt: e_nxt, pred: e_pred});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".cur"},  32'(pc_cur),     32'(e.cur));
    check({t, ".next"}, 32'(pc_nxt),     32'(e.nxt));
    check({t, ".pred"}, 32'(pred_taken), 32'(e.pred));
    @(posedge clk);
    #1;
  endtask

  // Shorthands: free-running fetch, redirect, and BTB update cycles.
  task automatic run(input string tag, input logic [AW-1:0] c,
                     input logic [AW-1:0] n, input logic p);
    step(tag, 0, 0, '0, 0, '0, 0, '0, c, n, p);
  endtask

  task automatic redirect(input string tag, input logic [AW-1:0] to,
                          input logic [AW-1:0] c, input logic p);
    step(tag, 0, 1, to, 0, '0, 0, '0, c, to, p);
  endtask

  task automatic update(input string tag, input logic [AW-1:0] bpc,
                        input logic tk, input logic [AW-1:0] tgt,
                        input logic [AW-1:0] c, input logic [AW-1:0] n,
                        input logic p);
    step(tag, 0, 0, '0, 1, bpc, tk, tgt, c, n, p);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; redir_v = 0; redir_pc = '0;
    upd_v = 0; upd_pc = '0; upd_taken = 0; upd_tgt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc",   32'(pc_cur),     32'h0);
    check("reset.pred", 32'(pred_taken), 32'h0);
    rst_n = 1'b1;

    // Sequential fetch.
    run("seq0", 26'h00, 26'h04, 0);
    run("seq1", 26'h04, 26'h08, 0);
    run("seq2", 26'h08, 26'h0C, 0);
    run("seq3", 26'h0C, 26'h10, 0);

    // Stall holds for three cycles, then resumes.
    for (int i = 0; i < 3; i++)
      step("stall", 1, 0, '0, 0, '0, 0, '0, 26'h10, 26'h10, 0);
    run("unstall0", 26'h10, 26'h14, 0);
    run("unstall1", 26'h14, 26'h18, 0);

    // Redirect wins over stall.
    step("redir_stall", 1, 1, 26'h200, 0, '0, 0, '0, 26'h18, 26'h200, 0);
    run("after_redir", 26'h200, 26'h204, 0);

    // Allocate 0x40 -> 0x100 and fetch through it.
    update("alloc40", 26'h40, 1, 26'h100, 26'h204, 26'h208, 0);
    redirect("to40a", 26'h40, 26'h208, 0);
    run("pred40", 26'h40, 26'h100, 1);
    run("at100", 26'h100, 26'h104, 0);

    // Train down to strongly not-taken.
    update("nt1", 26'h40, 0, 26'h100, 26'h104, 26'h108, 0);
    update("nt2", 26'h40, 0, 26'h100, 26'h108, 26'h10C, 0);
    redirect("to40b", 26'h40, 26'h10C, 0);
    run("cnt0", 26'h40, 26'h44, 0);
    // 0 -> 1: still not-taken.
    update("t1", 26'h40, 1, 26'h100, 26'h44, 26'h48, 0);
    redirect("to40c", 26'h40, 26'h48, 0);
    // 1 -> 2 on the same cycle 0x40 is looked up: lookup sees the old counter.
    update("t2_nobypass", 26'h40, 1, 26'h100, 26'h40, 26'h44, 0);
    redirect("to40d", 26'h40, 26'h44, 0);
    run("cnt2", 26'h40, 26'h100, 1);

    // Aliasing: 0x80 shares index 0 and evicts 0x40.
    update("alloc80", 26'h80, 1, 26'h300, 26'h100, 26'h104, 0);
    redirect("to40e", 26'h40, 26'h104, 0);
    run("alias40_miss", 26'h40, 26'h44, 0);
    redirect("to80", 26'h80, 26'h44, 0);
    run("pred80", 26'h80, 26'h300, 1);
    run("at300", 26'h300, 26'h304, 0);

    // Address wrap.
    redirect("to_top", 26'h3FFFFFC, 26'h304, 0);
    run("wrap", 26'h3FFFFFC, 26'h0, 0);
    run("after_wrap", 26'h0, 26'h4, 0);

    // Stall outranks a taken prediction.
    redirect("to80b", 26'h80, 26'h4, 0);
    step("stall_pred", 1, 0, '0, 0, '0, 0, '0, 26'h80, 26'h80, 1);
    run("pred80b", 26'h80, 26'h300, 1);

    // Mid-run reset: PC returns to 0 and valid bits clear.
    rst_n = 1'b0;
    run("mid_reset", 26'h300, 26'h304, 0);
    rst_n = 1'b1;
    run("post_reset", 26'h0, 26'h4, 0);
    redirect("to80c", 26'h80, 26'h4, 0);
    run("cleared80", 26'h80, 26'h84, 0);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
